pulse_generator: RTL
====================

Name: pulse_generator

Overview:
- Transmit-side counterpart to the tag-path rising-edge detector.
- Converts single-cycle trigger strobes into clean, registered, glitch-free pulses on a tag output line.
- Each pulse has a programmable high time and a guaranteed minimum low time, so a 3-flop synchronizer plus edge detector in another clock domain sees exactly one rising edge per trigger.
- Triggers that arrive while a pulse is in flight are queued in a saturating counter and replayed back-to-back.

Parameters:
- CW, 16, width of the high/low length inputs and the internal cycle counter.
- PW, 8, width of the pending-trigger counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  block enable. Low = synchronous abort/flush (see Behaviour).
- trig  in  1  pulse request. Each high cycle is one request.
- high_len  in  CW  pulse high time in clk cycles. 0 is treated as 1.
- low_len  in  CW  minimum low time after a pulse in clk cycles. Values <2 are treated as 2.
- dout  out  1  registered pulse output.
- busy  out  1  high when state != IDLE.
- pending  out  PW  number of queued, not-yet-started requests.
- overflow  out  1  sticky. Set when a request is dropped because pending is saturated.
- pulse_cnt  out  16  pulses started, wraps modulo 2^16.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, dout=0, busy=0, pending=0, overflow=0, pulse_cnt=0, internal counter=0. rst overrides enable.
- States: IDLE, HIGH, LOW.
- Request present = trig=1 or pending>0.
- IDLE -> HIGH when enable=1 and a request is present.
- Pulse start, in the same cycle as IDLE -> HIGH:
  - latch hl = max(high_len,1) and ll = max(low_len,2);
  - pulse_cnt += 1;
  - consume one request: pending unchanged if trig=1 and pending>0 (trig enqueued, one dequeued); pending unchanged if trig=1 and pending=0 (trig consumed directly); pending -= 1 if trig=0.
- Latency: trig sampled at edge n makes dout=1 from edge n+1. dout is a flop output, never combinational.
- HIGH: dout=1 for exactly hl cycles, then -> LOW.
- LOW: dout=0 for exactly ll cycles. At the end of the last LOW cycle:
  - request present and enable=1 -> HIGH directly (no extra IDLE cycle), with the same start actions as above;
  - otherwise -> IDLE.
- Minimum period back-to-back is hl+ll cycles.
- trig in HIGH/LOW (not a start cycle): pending += 1.
  - If pending = 2^PW-1, pending holds and overflow is set to 1.
  - overflow clears only on rst.
- high_len and low_len are sampled only at pulse start. Changes mid-pulse have no effect on the current pulse.
- enable=0 at a clk edge, any state:
  - next state IDLE, dout=0, pending=0, internal counter=0;
  - trig is ignored while enable=0;
  - overflow and pulse_cnt hold.
  - An aborted HIGH is truncated. The next pulse after enable returns still starts from IDLE.
- enable 0->1 with trig=1 in the same cycle: the trig is accepted and the pulse starts (dout=1 next cycle).
- busy = (state != IDLE), registered with the state.
- pulse_cnt wraps 0xFFFF -> 0x0000 without a flag.

Test Plan:
- Single pulse: high_len=3, low_len=4, one trig at cycle 10 -> dout=1 cycles 11-13, 0 from cycle 14; busy=1 cycles 11-17, 0 at 18; pulse_cnt=1; pending=0 throughout.
- Burst: high_len=2, low_len=3, trig high cycles 10-12 -> pending peaks at 2; dout high 11-12, 16-17, 21-22, low otherwise; pulse_cnt=3; pending=0 at cycle 21; busy low from cycle 26.
- Clamping: high_len=0, low_len=0, two trigs at cycles 5 and 6 -> dout high at 6 and 9, low at 7-8 and 10-11; pulse_cnt=2.
- Overflow (PW=2): high_len=20, start a pulse, then 5 extra trigs during HIGH -> pending=3, overflow=1; exactly 4 pulses total; overflow still 1 after the queue drains.
- Abort: enable dropped at cycle 2 of HIGH with pending=2 -> dout=0 next cycle, pending=0, busy=0, pulse_cnt unchanged. Re-enable plus trig -> full-length pulse one cycle later.
- Reset mid-LOW with pending=1 and overflow=1 -> all outputs zero the next cycle, no pulse emitted afterwards without a new trig. Also cover the high_len change mid-pulse case: the current pulse width is unaffected and the new value applies to the next pulse.

Source files
------------

// File: rtl/pulse_generator.sv
// Turns single-cycle trigger strobes into registered pulses with a programmable
// high time and an enforced minimum low time; overlapping triggers are queued.
module pulse_generator #(
  parameter int CW = 16,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          trig,
  input  logic [CW-1:0] high_len,
  input  logic [CW-1:0] low_len,
  output logic          dout,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow,
  output logic [15:0]   pulse_cnt,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ll_q, ll_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   pcnt_q, pcnt_d;
  logic          dout_q, dout_d;
  logic          busy_q, busy_d;

  logic          req;
  logic          start;
  logic [CW-1:0] hl_eff;
  logic [CW-1:0] ll_eff;

  assign req    = trig || (pend_q != '0);
  assign hl_eff = (high_len == '0) ? CW'(1) : high_len;
  assign ll_eff = (low_len < CW'(2)) ? CW'(2) : low_len;

  // cnt_q holds the cycles remaining in the current phase after this one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ll_d    = ll_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    pcnt_d  = pcnt_q;
    start   = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) start = 1'b1;
        end
        HIGH: begin
          if (cnt_q == '0) begin
            state_d = LOW;
            cnt_d   = ll_q - CW'(1);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        LOW: begin
          if (cnt_q == '0) begin
            if (req) start = 1'b1;
            else     state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase

      // A start consumes one request; a trig in the same cycle replaces it.
      if (start) begin
        state_d = HIGH;
        cnt_d   = hl_eff - CW'(1);
        ll_d    = ll_eff;
        pcnt_d  = pcnt_q + 16'd1;
        if (!trig) pend_d = pend_q - PW'(1);
      end else if (trig && (state_q != IDLE)) begin
        if (pend_q == {PW{1'b1}}) ovf_d = 1'b1;
        else                      pend_d = pend_q + PW'(1);
      end
    end

    dout_d = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ll_q    <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      pcnt_q  <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ll_q    <= ll_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      pcnt_q  <= pcnt_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

  assign dout      = dout_q;
  assign busy      = busy_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;
  assign pulse_cnt = pcnt_q;
  assign state_dbg = state_q;

endmodule
